wb_unit: RTL and testbench

- Writeback stage: the single writer of the integer register file.
- Merges two result streams into one registered write port (wen/waddr/wdata) driving the register file:
  - single-cycle ALU results;
  - variable-latency LSU/long-op results.
- Keeps a pending-register scoreboard for long-latency destinations.
- Provides same-cycle bypass data to the decode/read side, since the register file only updates at the clock edge.

---
 rtl/wb_pkg.sv | 12 +
 rtl/wb_fifo.sv | 36 +++
 rtl/wb_unit.sv | 66 ++++++
 tb/tb_wb_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared writeback types, widths and scoreboard mask helper
package wb_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0] data;
  } wb_req_t;
  function automatic logic [31:0] rd_mask(input logic [REG_ADDR_W-1:0] rd);
    return (32'd1 << rd) & ~32'd1;
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of writeback requests with registered occupancy
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  wb_req_t din,
  output logic    full,
  output logic    empty,
  output wb_req_t head
);
  localparam int AW = $clog2(DEPTH);
  wb_req_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/wb_unit.sv
// wb_unit: writeback stage merging ALU and buffered LSU results into the
// register file write port, with long-op scoreboard and same-cycle bypass
module wb_unit #(
  parameter int XLEN = 32,
  parameter int LSU_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic            sb_set,
  input  logic [4:0]      sb_rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            busy1,
  output logic            busy2,
  output logic            fwd1_hit,
  output logic            fwd2_hit,
  output logic [XLEN-1:0] fwd_data,
  output logic            wen,
  output logic [4:0]      waddr,
  output logic [XLEN-1:0] wdata
);
  import wb_pkg::*;
  wb_req_t alu_req, lsu_req, head, sel, wb_q;
  logic full, empty, push, pop, load;
  logic [31:0] pending, set_mask, clr_mask;
  assign alu_req = {alu_rd, alu_data};
  assign lsu_req = {lsu_rd, lsu_data};
  assign lsu_ready = !rst && !full;
  assign push = lsu_valid && lsu_ready;
  assign pop = !alu_valid && !empty;
  assign load = alu_valid || pop;
  assign sel = alu_valid ? alu_req : head;
  wb_fifo #(.DEPTH(LSU_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(lsu_req),
    .full(full), .empty(empty), .head(head)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      wen <= 1'b0;
      wb_q <= '0;
    end else begin
      wen <= load && sel.rd != '0;
      if (load) wb_q <= sel;
    end
  end
  assign set_mask = sb_set ? rd_mask(sb_rd) : '0;
  assign clr_mask = pop ? rd_mask(head.rd) : '0;
  // set is applied after clear so a relaunch to the same rd stays pending
  always_ff @(posedge clk)
    if (rst) pending <= '0;
    else pending <= (pending & ~clr_mask) | set_mask;
  assign waddr = wb_q.rd;
  assign wdata = wb_q.data;
  assign fwd_data = wdata;
  assign busy1 = pending[rs1];
  assign busy2 = pending[rs2];
  assign fwd1_hit = wen && waddr == rs1 && rs1 != '0;
  assign fwd2_hit = wen && waddr == rs2 && rs2 != '0;
endmodule

// File: tb/tb_wb_unit.sv
// tb_wb_unit: directed vectors; expected writes queued with their cycle and
// checked by a negedge monitor, side-band outputs checked mid-cycle
module tb_wb_unit;
  logic clk = 0, rst = 1;
  logic alu_valid = 0, lsu_valid = 0, sb_set = 0;
  logic [4:0] alu_rd = 0, lsu_rd = 0, sb_rd = 0, rs1 = 0, rs2 = 0;
  logic [31:0] alu_data = 0, lsu_data = 0;
  logic lsu_ready, busy1, busy2, fwd1_hit, fwd2_hit, wen;
  logic [4:0] waddr;
  logic [31:0] fwd_data, wdata;
  int n_cmp = 0, n_bad = 0, cyc = 0, t0;
  typedef struct {int c; logic [4:0] a; logic [31:0] d;} exp_t;
  exp_t q[$];

  wb_unit #(.XLEN(32), .LSU_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .sb_set(sb_set), .sb_rd(sb_rd), .rs1(rs1), .rs2(rs2), .busy1(busy1), .busy2(busy2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd_data(fwd_data),
    .wen(wen), .waddr(waddr), .wdata(wdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expw(input int c, input logic [4:0] a, input logic [31:0] d);
    q.push_back('{c, a, d});
  endtask

  always @(negedge clk)
    if (wen === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got waddr %0d wdata %h, expected no write (cycle %0d)", waddr, wdata, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("write_cycle", cyc, e.c);
        chk("waddr", {27'd0, waddr}, {27'd0, e.a});
        chk("wdata", wdata, e.d);
      end
    end

  initial begin
    tick();
    chk("rst_wen", {31'd0, wen}, 0);
    chk("rst_waddr", {27'd0, waddr}, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_ready", {31'd0, lsu_ready}, 0);
    tick();
    rst = 0;
    tick();
    chk("post_rst_ready", {31'd0, lsu_ready}, 1);
    // ALU only
    t0 = cyc;
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF; rs1 = 5;
    expw(t0 + 1, 5, 32'hDEADBEEF);
    tick();
    alu_valid = 0;
    #1;
    chk("alu_wen", {31'd0, wen}, 1);
    chk("alu_fwd1", {31'd0, fwd1_hit}, 1);
    chk("alu_fwd_data", fwd_data, 32'hDEADBEEF);
    tick();
    // x0 suppression
    alu_valid = 1; alu_rd = 0; alu_data = 32'h1234; rs1 = 0;
    tick();
    alu_valid = 0;
    #1;
    chk("x0_wen", {31'd0, wen}, 0);
    chk("x0_fwd1", {31'd0, fwd1_hit}, 0);
    tick();
    // contention: ALU busy cycles 0-3, LSU pushes at 0 and 1
    t0 = cyc;
    expw(t0 + 1, 1, 32'h11); expw(t0 + 2, 2, 32'h22); expw(t0 + 3, 3, 32'h33);
    expw(t0 + 4, 4, 32'h44); expw(t0 + 5, 7, 32'h77); expw(t0 + 6, 8, 32'h88);
    alu_valid = 1; alu_rd = 1; alu_data = 32'h11;
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h77;
    #1 chk("cont_ready_c0", {31'd0, lsu_ready}, 1);
    tick();
    alu_rd = 2; alu_data = 32'h22; lsu_rd = 8; lsu_data = 32'h88;
    #1 chk("cont_ready_c1", {31'd0, lsu_ready}, 1);
    tick();
    lsu_valid = 0; alu_rd = 3; alu_data = 32'h33;
    #1 chk("cont_ready_c2", {31'd0, lsu_ready}, 0);
    tick();
    alu_rd = 4; alu_data = 32'h44;
    #1 chk("cont_ready_c3", {31'd0, lsu_ready}, 0);
    tick();
    alu_valid = 0;
    #1 chk("cont_ready_c4", {31'd0, lsu_ready}, 0);
    tick();
    #1 chk("cont_ready_c5", {31'd0, lsu_ready}, 1);
    tick();
    tick();
    // scoreboard
    t0 = cyc;
    sb_set = 1; sb_rd = 9; rs1 = 9;
    #1 chk("sb_busy_c0", {31'd0, busy1}, 0);
    tick();
    sb_set = 0;
    #1 chk("sb_busy_c1", {31'd0, busy1}, 1);
    tick();
    #1 chk("sb_busy_c2", {31'd0, busy1}, 1);
    tick();
    lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h99;
    expw(t0 + 5, 9, 32'h99);
    #1 chk("sb_busy_c3", {31'd0, busy1}, 1);
    tick();
    lsu_valid = 0;
    #1 chk("sb_busy_c4", {31'd0, busy1}, 1);
    tick();
    #1;
    chk("sb_busy_c5", {31'd0, busy1}, 0);
    chk("sb_fwd_c5", {31'd0, fwd1_hit}, 1);
    chk("sb_wen_c5", {31'd0, wen}, 1);
    tick();
    // same-cycle set and clear of rd 9
    sb_set = 1; sb_rd = 9;
    tick();
    sb_set = 0;
    t0 = cyc;
    lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h5;
    expw(t0 + 2, 9, 32'h5);
    tick();
    lsu_valid = 0; sb_set = 1; sb_rd = 9;
    tick();
    sb_set = 0;
    #1;
    chk("setclr_busy_write", {31'd0, busy1}, 1);
    chk("setclr_fwd", {31'd0, fwd1_hit}, 1);
    tick();
    #1 chk("setclr_busy_after", {31'd0, busy1}, 1);
    // reset mid-operation with full buffer and pending[3]
    t0 = cyc;
    sb_set = 1; sb_rd = 3; rs2 = 3;
    alu_valid = 1; alu_rd = 10; alu_data = 32'hA0;
    lsu_valid = 1; lsu_rd = 11; lsu_data = 32'hB0;
    expw(t0 + 1, 10, 32'hA0); expw(t0 + 2, 12, 32'hC0);
    tick();
    sb_set = 0;
    alu_rd = 12; alu_data = 32'hC0; lsu_rd = 13; lsu_data = 32'hD0;
    tick();
    alu_valid = 0; lsu_valid = 0;
    #1;
    chk("full_ready", {31'd0, lsu_ready}, 0);
    chk("full_busy2", {31'd0, busy2}, 1);
    rst = 1;
    #1 chk("rst_forces_ready", {31'd0, lsu_ready}, 0);
    tick();
    rst = 0;
    #1;
    chk("mid_rst_wen", {31'd0, wen}, 0);
    chk("mid_rst_waddr", {27'd0, waddr}, 0);
    chk("mid_rst_ready", {31'd0, lsu_ready}, 1);
    chk("mid_rst_busy1", {31'd0, busy1}, 0);
    chk("mid_rst_busy2", {31'd0, busy2}, 0);
    repeat (6) tick();
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
